// File: rtl/uart_tx_serializer.sv
// Transmit serializer: pops bytes from a fall-through TX FIFO and frames them
// (start, 5..8 data bits LSB first, optional parity, 1/1.5/2 stop) on a 16x baud strobe.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] lcr,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  output logic       tx_o,
  output logic       thre_o,
  output logic       temt_o
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST       = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_HALF_LAST = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] STOP_TWO_LAST  = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // LCR layout: [1:0] wls, [2] stb, [3] pen, [4] eps, [5] stick parity, [6] set break
  logic [1:0] lcr_wls;
  logic       lcr_set_break;
  assign lcr_wls       = lcr[1:0];
  assign lcr_set_break = lcr[6];

  state_t         state_reg, state_next;
  logic [TW-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     data_reg, data_next;
  logic [1:0]     wls_reg, wls_next;
  logic           stb_reg, stb_next;
  logic           pen_reg, pen_next;
  logic           eps_reg, eps_next;
  logic           stick_reg, stick_next;
  logic           tx_reg, tx_next;
  logic           thre_reg;
  logic           temt_reg;

  logic           pop;
  logic           last_tick;
  logic [TW-1:0]  cur_last;
  logic [2:0]     bit_last;
  logic [7:0]     data_mask;
  logic           parity_bit;
  logic           line_level;

  assign bit_last = 3'd4 + 3'(wls_reg);

  // Mask off the unused upper bits of the latched byte for parity.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign data_mask[gi] = (3'(gi) <= bit_last);
    end
  endgenerate

  always_comb begin
    parity_bit = 1'b0;
    if (stick_reg) begin
      parity_bit = ~eps_reg;
    end else if (eps_reg) begin
      parity_bit = ^(data_reg & data_mask);
    end else begin
      parity_bit = ~(^(data_reg & data_mask));
    end
  end

  always_comb begin
    cur_last = BIT_LAST;
    if (state_reg == STOP && stb_reg) begin
      cur_last = (wls_reg == 2'b00) ? STOP_HALF_LAST : STOP_TWO_LAST;
    end
  end

  assign last_tick = baud_tick && (tick_cnt_reg == cur_last);

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    wls_next      = wls_reg;
    stb_next      = stb_reg;
    pen_next      = pen_reg;
    eps_next      = eps_reg;
    stick_next    = stick_reg;
    pop           = 1'b0;
    line_level    = 1'b1;
    tx_next       = 1'b1;

    if (baud_tick && state_reg != IDLE) begin
      tick_cnt_next = last_tick ? '0 : tick_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (baud_tick && !fifo_empty) begin
          pop           = 1'b1;
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (last_tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (last_tick) begin
          if (bit_cnt_reg == bit_last) begin
            bit_cnt_next = '0;
            state_next   = pen_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          // Chain straight into the next frame's start bit when data is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (pop) begin
      data_next  = fifo_rdata;
      wls_next   = lcr_wls;
      stb_next   = lcr[2];
      pen_next   = lcr[3];
      eps_next   = lcr[4];
      stick_next = lcr[5];
    end

    case (state_next)
      START:   line_level = 1'b0;
      DATA:    line_level = data_next[bit_cnt_next];
      PARITY:  line_level = parity_bit;
      default: line_level = 1'b1;
    endcase

    tx_next = lcr_set_break ? 1'b0 : line_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      wls_reg      <= '0;
      stb_reg      <= 1'b0;
      pen_reg      <= 1'b0;
      eps_reg      <= 1'b0;
      stick_reg    <= 1'b0;
      tx_reg       <= 1'b1;
      thre_reg     <= 1'b1;
      temt_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      wls_reg      <= wls_next;
      stb_reg      <= stb_next;
      pen_reg      <= pen_next;
      eps_reg      <= eps_next;
      stick_reg    <= stick_next;
      tx_reg       <= tx_next;
      thre_reg     <= fifo_empty;
      temt_reg     <= (state_reg == IDLE) && fifo_empty;
    end
  end

  // Pop is combinational with the latch cycle; held off while reset is asserted.
  assign fifo_rd = pop && rst_n;
  assign tx_o    = tx_reg;
  assign thre_o  = thre_reg;
  assign temt_o  = temt_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: fall-through FIFO model, baud strobe every
// 4 clk, mid-bit sampling of tx_o against hand-computed frame patterns.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] lcr = 8'h00;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;
  logic       tx_o;
  logic       thre_o;
  logic       temt_o;

  uart_tx_serializer #(.OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .lcr        (lcr),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .tx_o       (tx_o),
    .thre_o     (thre_o),
    .temt_o     (temt_o)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = fifo_mem[rd_ptr % 16];

  int tick_n = 0;
  int pops = 0;
  int empty_pops = 0;
  int pop_tick [0:15];
  int bdiv = 0;
  int total = 0;
  int bad = 0;

  // Baud strobe every 4 clk; tick_n counts strobes the DUT has seen.
  always @(posedge clk) begin
    bdiv      <= (bdiv == 3) ? 0 : bdiv + 1;
    baud_tick <= (bdiv == 3);
    if (baud_tick) tick_n <= tick_n + 1;
    if (fifo_rd) begin
      if (fifo_empty) empty_pops <= empty_pops + 1;
      pop_tick[pops % 16] <= tick_n + 1;
      pops   <= pops + 1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr % 16] = d;
    wr_ptr++;
  endtask

  task automatic wait_tick(input int target);
    int guard = 0;
    while (tick_n < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (tick_n < target) check("tick_timeout", 32'(tick_n), 32'(target));
  endtask

  task automatic wait_pop(input int idx);
    int guard = 0;
    while (pops <= idx && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (pops <= idx) check("pop_timeout", 32'(pops), 32'(idx + 1));
  endtask

  // exp_bits[0] is the start bit; each element is sampled mid-bit (tick 8 of 16).
  task automatic check_frame(input int idx, input int nel, input logic [15:0] exp_bits,
                             input int flen, input bit last, input string tag);
    int p;
    wait_pop(idx);
    p = pop_tick[idx % 16];
    for (int b = 0; b < nel; b++) begin
      wait_tick(p + 16 * b + 8);
      check($sformatf("%s_bit%0d", tag, b), 32'(tx_o), 32'(exp_bits[b]));
    end
    wait_tick(p + flen - 1);
    @(negedge clk);
    check({tag, "_stop_tail"}, 32'(tx_o), 32'd1);
    check({tag, "_temt_busy"}, 32'(temt_o), 32'd0);
    wait_tick(p + flen);
    if (last) begin
      @(negedge clk);
      check({tag, "_temt_idle"}, 32'(temt_o), 32'd1);
      check({tag, "_tx_idle"}, 32'(tx_o), 32'd1);
    end else begin
      check({tag, "_next_pop_tick"}, 32'((pops > idx + 1) ? pop_tick[(idx + 1) % 16] : -1),
            32'(p + flen));
      check({tag, "_next_start"}, 32'(tx_o), 32'd0);
    end
  endtask

  initial begin
    int p;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_thre", 32'(thre_o), 32'd1);
    check("rst_temt", 32'(temt_o), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, 0x55
    lcr = 8'h03;
    push(8'h55);
    @(negedge clk);
    check("t1_thre_busy", 32'(thre_o), 32'd0);
    check_frame(0, 10, 16'h02AA, 160, 1'b1, "t1_8n1");
    check("t1_pops", 32'(pops), 32'd1);

    // 7E1, 0x41: 1,0,0,0,0,0,1 parity 0
    lcr = 8'h1A;
    push(8'h41);
    check_frame(1, 10, 16'h0282, 160, 1'b1, "t2_7e1");

    // 5 data bits, 1.5 stop, 0x1F
    lcr = 8'h04;
    push(8'h1F);
    check_frame(2, 7, 16'h007E, 120, 1'b1, "t3_5n15");

    // Mark parity, back-to-back 0x00 then 0xFF
    lcr = 8'h2B;
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    check("t4_thre_busy", 32'(thre_o), 32'd0);
    check_frame(3, 11, 16'h0600, 176, 1'b0, "t4_mark00");
    check_frame(4, 11, 16'h07FE, 176, 1'b1, "t4_markff");
    check("t4_thre_idle", 32'(thre_o), 32'd1);
    check("t4_pops", 32'(pops), 32'd5);

    // Break during DATA of 0xA5 (bit2 would be 1, bit5 is 1 after release)
    lcr = 8'h03;
    push(8'hA5);
    wait_pop(5);
    p = pop_tick[5];
    wait_tick(p + 40);
    lcr = 8'h43;
    wait_tick(p + 44);
    check("brk_early", 32'(tx_o), 32'd0);
    wait_tick(p + 56);
    check("brk_over_one", 32'(tx_o), 32'd0);
    wait_tick(p + 72);
    check("brk_late", 32'(tx_o), 32'd0);
    wait_tick(p + 80);
    lcr = 8'h03;
    wait_tick(p + 104);
    check("brk_released_bit5", 32'(tx_o), 32'd1);
    wait_tick(p + 152);
    check("brk_stop", 32'(tx_o), 32'd1);
    wait_tick(p + 159);
    @(negedge clk);
    check("brk_temt_busy", 32'(temt_o), 32'd0);
    wait_tick(p + 160);
    @(negedge clk);
    check("brk_temt_idle", 32'(temt_o), 32'd1);
    check("brk_pops", 32'(pops), 32'd6);

    // Reset during PARITY of 0x41 (7E1), 0x33 queued behind it
    lcr = 8'h1A;
    push(8'h41);
    push(8'h33);
    wait_pop(6);
    p = pop_tick[6];
    wait_tick(p + 136);
    check("rst_mid_parity", 32'(tx_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx_o), 32'd1);
    check("rst_mid_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_mid_temt", 32'(temt_o), 32'd1);
    repeat (6) @(negedge clk);
    check("rst_mid_no_pop", 32'(pops), 32'd7);
    rst_n = 1'b1;
    // 0x33 7E1: 1,1,0,0,1,1,0 parity 0
    check_frame(7, 10, 16'h0266, 160, 1'b1, "t6_after_rst");

    check("final_pops", 32'(pops), 32'd8);
    check("final_empty_pops", 32'(empty_pops), 32'd0);
    check("final_thre", 32'(thre_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit serializer of the 16550 core. Sits between the TX FIFO (upstream) and the serial pin.
- Pops bytes from a first-word-fall-through TX FIFO and frames them per the current LCR.
- Produces the transmit line and the LSR THRE/TEMT status bits.
- Timing comes from a 16x-oversample baud strobe produced by the divisor-latch baud generator.

Parameters:
OVERSAMPLE, 16, baud_tick strobes per nominal bit period; must be even.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate
lcr  input  8  registers::lcr_t; uses wls, stb, pen, eps, stick_parity, set_break
fifo_empty  input  1  TX FIFO empty flag
fifo_rdata  input  8  TX FIFO head word, valid while !fifo_empty
fifo_rd  output  1  one-clk pop strobe to TX FIFO
tx_o  output  1  serial output, idle high
thre_o  output  1  holding register empty; equals fifo_empty, registered
temt_o  output  1  transmitter empty; FIFO empty and serializer idle

Behaviour:
- Reset values (async on rst_n low): tx_o=1, fifo_rd=0, thre_o=1, temt_o=1, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP.
- tick_cnt counts baud_tick within the current bit; bit_cnt counts data bits. Both advance only on baud_tick.
- IDLE:
  - On a cycle with baud_tick=1 and fifo_empty=0: assert fifo_rd for exactly that cycle.
  - Same cycle: latch fifo_rdata into the shift register and latch wls/stb/pen/eps/stick_parity into a frame-config register.
  - Go to START.
  - LCR changes mid-frame do not affect the current frame, except set_break.
- START: drive 0 for OVERSAMPLE ticks.
- DATA:
  - Drive the shift register LSB first.
  - Data bit count = 5 + wls (5..8). Upper unused bits of the latched byte are ignored.
  - Each bit lasts OVERSAMPLE ticks.
- PARITY (entered only if pen=1, else skip to STOP), computed over the transmitted bits only:
  - stick_parity=0, eps=1: even parity; bit = XOR of data bits.
  - stick_parity=0, eps=0: odd parity; bit = inverted XOR.
  - stick_parity=1: bit = ~eps (constant 1 when eps=0, constant 0 when eps=1).
- STOP: drive 1.
  - Length is OVERSAMPLE ticks if stb=0.
  - If stb=1: 1.5 x OVERSAMPLE when wls=00, else 2 x OVERSAMPLE.
- End of the last STOP tick:
  - If fifo_empty=0: pop in that same cycle and go directly to START. No idle gap between frames.
  - Otherwise go to IDLE.
- tx_o is registered. It changes on the clk edge following the baud_tick that ends the previous bit. Start-bit falling edge is exactly 1 clk after the pop cycle.
- Break: while lcr.set_break=1, tx_o is forced to 0. The FSM keeps running and FIFO pops continue, so data is lost; this is 16550 behaviour. Releasing break restores the FSM-driven level on the next clk.
- thre_o = registered fifo_empty (1 clk latency).
- temt_o = registered (state==IDLE && fifo_empty). temt_o is 0 from the pop cycle +1 until 1 clk after returning to IDLE with the FIFO empty.
- fifo_rd is never asserted when fifo_empty=1. Pops happen at most once per frame.
- Reset mid-frame: tx_o returns to 1 immediately (async). The partially sent byte is discarded. No pop occurs until the next qualifying baud_tick after reset release.
- baud_tick held high continuously is legal; the FSM then advances once per clk.

Test Plan:
- 8N1 (lcr=0x03), push 0x55, baud_tick every 4 clk:
  - Exactly one fifo_rd pulse.
  - tx_o = 0,1,0,1,0,1,0,1,0,1 at 16 ticks per bit, then high.
  - Frame = 160 ticks; temt_o returns to 1 afterwards.
- 7E1 (lcr=0x1A), push 0x41:
  - Data bits 1,0,0,0,0,0,1, then parity 0, then 1 stop.
  - Frame = 160 ticks.
- 5 bits, stb=1 (lcr=0x04), push 0x1F: data 1,1,1,1,1, stop high for 24 ticks; total frame 120 ticks.
- Stick parity (lcr=0x2B, mark), push 0x00 then 0xFF:
  - Parity bit is 1 for both frames.
  - Back-to-back frames: stop-bit end is followed by the start bit with zero idle ticks; second pop occurs on the final stop tick.
- set_break asserted mid DATA of 0xA5 for 40 ticks:
  - tx_o is held 0 throughout.
  - FSM finishes the frame on schedule; after release, tx_o=1 in STOP/IDLE.
- rst_n pulsed low during PARITY:
  - tx_o=1, fifo_rd=0, temt_o=1 within the reset cycle.
  - The next queued byte transmits cleanly from a fresh start bit.
